fetch_f: RTL and testbench
==========================

// Module: fetch_F
// PURPOSE
//  Instruction fetch stage. Owns the PC, issues word reads to instruction memory and buffers the
//  returned words. Drives the F/D pipeline register (instr_D, pc_D, valid_D) feeding decode_D.
//  Honours decode's stall_F_D and the X-stage branch/jump redirect.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC fetched first after reset
//  BUF_DEPTH  2              fetch buffer entries; also the maximum number of outstanding imem reads
// PORTS
//  clk           in   1   clock, rising edge
//  rst_n         in   1   asynchronous, active-low reset
//  imem_req      out  1   read request valid
//  imem_addr     out  32  read word address; bits [1:0] always 2'b00
//  imem_gnt      in   1   request accepted this cycle when imem_req && imem_gnt
//  imem_rvalid   in   1   read data valid; responses return in order, >=1 cycle after grant
//  imem_rdata    in   32  read data
//  stall_F_D     in   1   decode stall; hold the F/D register
//  redirect      in   1   control-flow change resolved in X
//  redirect_pc   in   32  new PC; bits [1:0] forced to 0
//  instr_D       out  32  instruction to decode
//  pc_D          out  32  PC of instr_D
//  valid_D       out  1   instr_D is real; 0 means bubble
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - pc=RESET_PC, buffer empty, outstanding=0, drop=0
//   - imem_req=0, instr_D=NOP (32'h0000_0013), pc_D=0, valid_D=0
//  Request rule:
//   - imem_req=1 iff outstanding + buffered < BUF_DEPTH and redirect=0
//   - imem_addr=pc, combinational; pc+=4 on grant
//   - imem_req may drop without a grant
//  Response:
//   - imem_rvalid with drop==0: push {pc_of_req, rdata} into buffer; outstanding--
//   - with drop>0: discard word; drop--, outstanding--
//   - request PCs tracked in a BUF_DEPTH-entry in-order tag queue
//  F/D register update:
//   - stall_F_D=1 and redirect=0: instr_D/pc_D/valid_D hold
//   - otherwise: pop buffer head into F/D with valid_D=1
//   - buffer empty: load NOP, valid_D=0
//   - a response arriving while the buffer is empty bypasses into F/D the same cycle (0-cycle buffer latency)
//  Redirect (priority over stall_F_D, rvalid and gnt):
//   - pc <= {redirect_pc[31:2],2'b00}; buffer flushed; F/D <= NOP, valid_D=0
//   - drop <= outstanding (minus any response discarded this cycle); outstanding bookkeeping continues
//   - no request issued in the redirect cycle; first new request the next cycle
//  Latency: redirect to valid_D=1 at the new PC is 2 cycles + imem latency
//  Boundaries:
//   - buffer full: imem_req=0
//   - response while full is impossible by the request rule; assertion in sim
//   - pc wraps 32'hFFFF_FFFC -> 0 silently
//   - grant and response in the same cycle: both counters updated; outstanding unchanged net
//   - rst_n low mid-transaction: all state cleared; late imem responses after release are not
//     filtered; the imem model is reset by the same rst_n
//  Counters: outstanding and drop are $clog2(BUF_DEPTH+1) bits; never underflow
// STRUCTURE
//  - Shared include "fetch_inc.v" (alongside imm_gen_inc.v): `NOP_INSTR 32'h0000_0013, `RESET_PC default
//  - One sub-module: fetch_buffer
//     - BUF_DEPTH-entry synchronous FIFO of {pc,instr} with push/pop/flush, count, full, empty
//     - flush dominates push
//  - PC, counters and F/D register stay in fetch_F
// TESTING
//  1 Reset, 0-wait imem, 1-cycle latency -> imem_addr 0,4,8...; valid_D=1 from cycle 3;
//    pc_D increments by 4 each cycle
//  2 stall_F_D=1 for 3 cycles at pc_D=8 -> instr_D/pc_D held; buffer fills to 2; imem_req=0;
//    release -> pc_D 12,16 on consecutive cycles
//  3 redirect to 32'h100 with 2 reads outstanding -> both responses discarded; valid_D=0 until
//    pc_D=32'h100 appears
//  4 imem_gnt=0 for 5 cycles -> imem_addr stable; valid_D=0 after buffer drains; no PC skipped
//  5 redirect and stall_F_D both high -> redirect wins; F/D=NOP, valid_D=0
//  6 redirect_pc=32'h203 -> fetch from 32'h200; pc at 32'hFFFF_FFFC wraps to 0

Source files
------------

// File: rtl/fetch_f_pkg.sv
// Shared constants, the fetch buffer entry type and small helpers for the fetch stage.
package fetch_f_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // Circular-pointer increment for queues whose depth need not be a power of two.
  function automatic int wrap_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fetch_f_if.sv
// Instruction-memory read port: request/grant for addresses, in-order rvalid for data.
interface fetch_f_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr,
                  input  imem_gnt, input imem_rvalid, input imem_rdata);
  modport slave  (input  imem_req, input imem_addr,
                  output imem_gnt, output imem_rvalid, output imem_rdata);
endinterface

// File: rtl/fetch_f_buffer.sv
// Small synchronous FIFO of fetched {pc, instr} pairs; flush dominates push and pop.
module fetch_f_buffer
  import fetch_f_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_push,
  input  fetch_entry_t                   i_data,
  input  logic                           i_pop,
  input  logic                           i_flush,
  output fetch_entry_t                   o_data,
  output logic [$clog2(DEPTH+1)-1:0]     o_count,
  output logic                           o_full,
  output logic                           o_empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t   r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           w_push;
  logic           w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_pop  = i_pop && !o_empty && !i_flush;
  assign w_push = i_push && (!o_full || w_pop) && !i_flush;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= PW'(wrap_inc(int'(r_wr_ptr), DEPTH));
      if (w_pop)  r_rd_ptr <= PW'(wrap_inc(int'(r_rd_ptr), DEPTH));
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is not reset; the count and pointers alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/fetch_f.sv
// Fetch stage: owns the PC, keeps at most BUF_DEPTH reads in flight or buffered,
// discards responses made stale by a redirect and drives the F/D pipeline register.
module fetch_f
  import fetch_f_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_f_if.master   imem,
  input  logic        i_stall_f_d,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_instr_d,
  output logic [31:0] o_pc_d,
  output logic        o_valid_d
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  logic [31:0]   r_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;
  logic [31:0]   r_tag_mem [BUF_DEPTH];
  logic [PW-1:0] r_tag_wr;
  logic [PW-1:0] r_tag_rd;
  logic [31:0]   r_instr_d;
  logic [31:0]   r_pc_d;
  logic          r_valid_d;

  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  fetch_entry_t  w_head;
  fetch_entry_t  w_rsp_entry;
  logic [CW:0]   w_occupancy;
  logic          w_req;
  logic          w_grant;
  logic          w_rsp_tracked;
  logic          w_rsp_keep;
  logic          w_advance;
  logic          w_pop;
  logic          w_bypass;
  logic          w_push;
  logic [CW-1:0] w_out_after_rsp;

  // Dropped-but-pending reads still occupy a slot, so they count against the request budget.
  assign w_occupancy = (CW+1)'(r_outstanding) + (CW+1)'(w_count);
  assign w_req       = rst_n && !i_redirect && (w_occupancy < (CW+1)'(BUF_DEPTH));
  assign w_grant     = w_req && imem.imem_gnt;

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_pc;

  assign w_rsp_tracked   = imem.imem_rvalid && (r_outstanding != '0);
  assign w_out_after_rsp = r_outstanding - CW'(w_rsp_tracked);
  assign w_rsp_keep      = imem.imem_rvalid && (r_drop == '0) && !i_redirect;
  assign w_rsp_entry     = fetch_entry_t'{pc: r_tag_mem[r_tag_rd], instr: imem.imem_rdata};

  assign w_advance = !i_stall_f_d && !i_redirect;
  assign w_pop     = w_advance && !w_empty;
  assign w_bypass  = w_advance && w_empty && w_rsp_keep;
  assign w_push    = w_rsp_keep && !w_bypass;

  fetch_f_buffer #(.DEPTH(BUF_DEPTH)) u_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_rsp_entry),
    .i_pop   (w_pop),
    .i_flush (i_redirect),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_tag_wr      <= '0;
      r_tag_rd      <= '0;
    end else begin
      r_outstanding <= w_out_after_rsp + CW'(w_grant);
      if (w_grant)       r_tag_wr <= PW'(wrap_inc(int'(r_tag_wr), BUF_DEPTH));
      if (w_rsp_tracked) r_tag_rd <= PW'(wrap_inc(int'(r_tag_rd), BUF_DEPTH));

      if (i_redirect) begin
        r_pc   <= word_align(i_redirect_pc);
        r_drop <= w_out_after_rsp;
      end else begin
        if (w_grant) r_pc <= r_pc + 32'd4;
        if (w_rsp_tracked && (r_drop != '0)) r_drop <= r_drop - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_grant) r_tag_mem[r_tag_wr] <= r_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_d <= NOP_INSTR;
      r_pc_d    <= '0;
      r_valid_d <= 1'b0;
    end else if (i_redirect) begin
      r_instr_d <= NOP_INSTR;
      r_pc_d    <= '0;
      r_valid_d <= 1'b0;
    end else if (!i_stall_f_d) begin
      if (w_pop) begin
        r_instr_d <= w_head.instr;
        r_pc_d    <= w_head.pc;
        r_valid_d <= 1'b1;
      end else if (w_bypass) begin
        r_instr_d <= w_rsp_entry.instr;
        r_pc_d    <= w_rsp_entry.pc;
        r_valid_d <= 1'b1;
      end else begin
        r_instr_d <= NOP_INSTR;
        r_pc_d    <= '0;
        r_valid_d <= 1'b0;
      end
    end
  end

  assign o_instr_d = r_instr_d;
  assign o_pc_d    = r_pc_d;
  assign o_valid_d = r_valid_d;

  // The request budget makes a push into a full, non-draining buffer unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(w_push && w_full && !w_pop));

endmodule

// File: tb/tb_fetch_f.sv
// Randomised bench for fetch_f: queue-level reference model, in-order imem model with
// variable latency, plus directed pins for reset, stall, redirect, grant starvation and wrap.
module tb_fetch_f;
  import fetch_f_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic        valid_d;

  always #5 clk = ~clk;

  fetch_f_if bus ();

  fetch_f #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (bus),
    .i_stall_f_d   (stall),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_instr_d     (instr_d),
    .o_pc_d        (pc_d),
    .o_valid_d     (valid_d)
  );

  typedef struct { logic [31:0] pc; bit dead; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [31:0] addr; int due; } imem_t;

  // Reference model: reads in flight (oldest first), buffered words, F/D contents.
  req_t        inflight[$];
  ent_t        fbuf[$];
  logic [31:0] m_pc;
  bit          m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc_d;

  imem_t imq[$];
  int    cyc;
  int    lat_lo, lat_hi, rv_pct;
  int    checks, errors;

  bit          s_valid, s_req;
  logic [31:0] s_instr, s_pc, s_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    inflight.delete();
    fbuf.delete();
    imq.delete();
    m_pc    = 32'h0;
    m_valid = 1'b0;
    m_instr = NOP_INSTR;
    m_pc_d  = 32'h0;
    cyc     = 0;
  endtask

  task automatic model_step(input bit st, input bit rd, input logic [31:0] rpc,
                            input bit granted, input bit rv);
    ent_t kept;
    ent_t head;
    req_t h;
    bit   have_kept = 1'b0;
    if (rv && inflight.size() > 0) begin
      h = inflight.pop_front();
      if (!h.dead && !rd) begin
        kept.pc    = h.pc;
        kept.instr = mem_word(h.pc);
        have_kept  = 1'b1;
      end
    end
    if (rd) begin
      fbuf.delete();
      foreach (inflight[i]) inflight[i].dead = 1'b1;
      m_pc    = rpc & ~32'h3;
      m_valid = 1'b0;
      m_instr = NOP_INSTR;
      m_pc_d  = 32'h0;
    end else begin
      if (granted) begin
        inflight.push_back('{pc: m_pc, dead: 1'b0});
        m_pc = m_pc + 32'd4;
      end
      if (!st) begin
        if (fbuf.size() > 0) begin
          head    = fbuf.pop_front();
          m_valid = 1'b1;
          m_instr = head.instr;
          m_pc_d  = head.pc;
        end else if (have_kept) begin
          m_valid   = 1'b1;
          m_instr   = kept.instr;
          m_pc_d    = kept.pc;
          have_kept = 1'b0;
        end else begin
          m_valid = 1'b0;
          m_instr = NOP_INSTR;
          m_pc_d  = 32'h0;
        end
      end
      if (have_kept) fbuf.push_back(kept);
    end
  endtask

  // One clock: drive inputs, compare against the model, then advance imem and model.
  task automatic cycle(input bit st, input bit rd, input logic [31:0] rpc, input bit gn);
    bit m_req;
    bit rv;
    @(negedge clk);
    stall        = st;
    redirect     = rd;
    redirect_pc  = rpc;
    bus.imem_gnt = gn;
    rv = (imq.size() > 0) && (imq[0].due <= cyc) && ($urandom_range(99) < rv_pct);
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rv ? mem_word(imq[0].addr) : $urandom;
    #1;
    m_req   = ((inflight.size() + fbuf.size()) < DEPTH) && !rd;
    s_valid = valid_d;
    s_instr = instr_d;
    s_pc    = pc_d;
    s_req   = bus.imem_req;
    s_addr  = bus.imem_addr;
    check("valid_d", {31'b0, s_valid}, {31'b0, m_valid});
    check("instr_d", s_instr, m_instr);
    if (m_valid) check("pc_d", s_pc, m_pc_d);
    check("imem_req", {31'b0, s_req}, {31'b0, m_req});
    check("imem_addr", s_addr, m_pc);
    @(posedge clk);
    if (rv) void'(imq.pop_front());
    if (s_req && gn) imq.push_back('{addr: s_addr, due: cyc + $urandom_range(lat_hi, lat_lo)});
    model_step(st, rd, rpc, gn && m_req, rv);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n           = 1'b0;
    stall           = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = 32'h0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    #1;
    check("rst_valid_d", {31'b0, valid_d}, 32'h0);
    check("rst_instr_d", instr_d, NOP_INSTR);
    check("rst_pc_d", pc_d, 32'h0);
    check("rst_imem_req", {31'b0, bus.imem_req}, 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    lat_lo = 1; lat_hi = 1; rv_pct = 100;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    model_clear();

    // Zero-wait imem, single-cycle latency, then a three-cycle stall at pc_D=8.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      cycle(k >= 4 && k <= 6, 1'b0, 32'h0, 1'b1);
      if (k == 0) begin
        check("pin_k0_req", {31'b0, s_req}, 32'h1);
        check("pin_k0_addr", s_addr, 32'h0);
        check("pin_k0_instr", s_instr, NOP_INSTR);
      end
      if (k == 2) check("pin_first_valid_pc", {s_valid, s_pc[30:0]}, 32'h8000_0000);
      if (k == 3) check("pin_pc4", s_pc, 32'h4);
      if (k == 4) check("pin_pc8", s_pc, 32'h8);
      if (k == 6) begin
        check("pin_stall_req", {31'b0, s_req}, 32'h0);
        check("pin_stall_hold", s_pc, 32'h8);
      end
      if (k == 8) check("pin_release_pc12", s_pc, 32'hC);
      if (k == 9) check("pin_release_pc16", s_pc, 32'h10);
    end

    // Latency 3: redirect with two reads in flight, then five cycles without grant.
    lat_lo = 3; lat_hi = 3;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, k == 2, 32'h100, !(k >= 9 && k <= 13));
      if (k == 4) check("pin_redir_addr", s_addr, 32'h100);
      if (k == 7) check("pin_redir_bubble", {31'b0, s_valid}, 32'h0);
      if (k == 8) check("pin_redir_first", {s_valid, s_pc[30:0]}, 32'h8000_0100);
      if (k == 9) check("pin_nognt_addr_a", s_addr, 32'h10C);
      if (k == 13) begin
        check("pin_nognt_addr_b", s_addr, 32'h10C);
        check("pin_nognt_drained", {31'b0, s_valid}, 32'h0);
      end
      if (k == 18) check("pin_no_skip", {s_valid, s_pc[30:0]}, 32'h8000_010C);
    end

    // Redirect beats stall; unaligned target; PC wrap at the top of memory.
    lat_lo = 1; lat_hi = 1;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      cycle(k == 3, (k == 3) || (k == 9), (k == 3) ? 32'h203 : 32'hFFFF_FFF8,
            !(k >= 6 && k <= 8));
      if (k == 4) begin
        check("pin_redir_stall_valid", {31'b0, s_valid}, 32'h0);
        check("pin_redir_stall_instr", s_instr, NOP_INSTR);
        check("pin_align_addr", s_addr, 32'h200);
      end
      if (k == 10) check("pin_wrap_addr_a", s_addr, 32'hFFFF_FFF8);
      if (k == 11) check("pin_wrap_addr_b", s_addr, 32'hFFFF_FFFC);
      if (k == 12) check("pin_wrap_addr_c", s_addr, 32'h0);
      if (k == 14) check("pin_wrap_pc_d", {s_valid, s_pc[30:0]}, 32'h8000_0000);
    end

    // Random traffic with variable latency, response gaps and occasional mid-run reset.
    lat_lo = 1; lat_hi = 4; rv_pct = 70;
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      logic [31:0] rpc;
      if ($urandom_range(599) == 0) do_reset();
      rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      cycle($urandom_range(99) < 30, $urandom_range(99) < 5, rpc, $urandom_range(99) < 70);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
